// File: rtl/gray_decode_pipe_if.sv
// ----------------------------------------------------------------------------
// gray_decode_pipe_if
// Handshake bundle for the pipelined Gray-to-binary decoder.
//   in_valid / in_ready / g     : upstream Gray word channel
//   out_valid / out_ready / b   : downstream binary word channel
//   step_err                    : delivered word broke one-bit adjacency
//   err_cnt                     : saturating count of delivered errored words
// Modports:
//   master : the side that produces g and consumes b (upstream + downstream)
//   slave  : the decoder itself
// ----------------------------------------------------------------------------
interface gray_decode_pipe_if #(
    parameter int unsigned WIDTH = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] g;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] b;
    logic             step_err;
    logic [7:0]       err_cnt;

    modport master (
        output in_valid, g, out_ready,
        input  in_ready, out_valid, b, step_err, err_cnt
    );

    modport slave (
        input  in_valid, g, out_ready,
        output in_ready, out_valid, b, step_err, err_cnt
    );
endinterface

// File: rtl/gray_decode_pipe.sv
// ----------------------------------------------------------------------------
// gray_decode_pipe
// Two-stage Gray-to-binary decoder with a valid/ready handshake on both sides.
// Each accepted word is checked against its predecessor for the Gray one-bit
// adjacency property; violations travel with the word as step_err.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (flushes both stages and history)
//   bus  : gray_decode_pipe_if.slave
//            in_valid/in_ready/g      upstream Gray word
//            out_valid/out_ready/b    downstream binary word
//            step_err                 adjacency violation flag for b
//            err_cnt                  saturating errored-delivery count
//
// Build option:
//   GRAY_DEC_ERRCNT_EN  defined   -> 8-bit saturating err_cnt register
//                       undefined -> err_cnt tied to zero, no counter logic
// ----------------------------------------------------------------------------
module gray_decode_pipe #(
    parameter int unsigned WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    gray_decode_pipe_if.slave  bus
);

    // Stage 1: raw Gray word plus its adjacency verdict
    logic [WIDTH-1:0] s1_g;
    logic             s1_v;
    logic             s1_err;

    // Stage 2: decoded word, drives the output channel
    logic [WIDTH-1:0] s2_b;
    logic             s2_v;
    logic             s2_err;

    // Last accepted word, for the adjacency check
    logic [WIDTH-1:0] prev;
    logic             prev_v;

    logic             s2_load;
    logic             in_fire;
    logic [WIDTH-1:0] diff;
    logic             one_bit;
    logic             adj_err;
    logic [WIDTH-1:0] dec;

    // S2 may take a new value when it is empty or its word leaves this cycle.
    // in_ready depends only on registered state and out_ready.
    assign s2_load      = !s2_v || bus.out_ready;
    assign bus.in_ready = !s1_v || s2_load;
    assign in_fire      = bus.in_valid && bus.in_ready;

    // Exactly one differing bit <=> diff is a nonzero power of two
    assign diff    = bus.g ^ prev;
    assign one_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    assign adj_err = prev_v && !one_bit;

    // Prefix XOR from the MSB down
    always_comb begin
        dec = '0;
        dec[WIDTH-1] = s1_g[WIDTH-1];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            dec[WIDTH-1-i] = dec[WIDTH-i] ^ s1_g[WIDTH-1-i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_g   <= '0;
            s1_v   <= 1'b0;
            s1_err <= 1'b0;
            prev   <= '0;
            prev_v <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_g   <= bus.g;
                s1_v   <= 1'b1;
                s1_err <= adj_err;
                prev   <= bus.g;
                prev_v <= 1'b1;
            end else if (s2_load) begin
                s1_v   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_b   <= '0;
            s2_v   <= 1'b0;
            s2_err <= 1'b0;
        end else if (s2_load) begin
            s2_b   <= dec;
            s2_v   <= s1_v;
            s2_err <= s1_err;
        end
    end

    assign bus.b         = s2_b;
    assign bus.out_valid = s2_v;
    assign bus.step_err  = s2_err;

`ifdef GRAY_DEC_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (s2_v && bus.out_ready && s2_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_gray_decode_pipe.sv
module tb_gray_decode_pipe;

    localparam int unsigned W = 3;

`ifdef GRAY_DEC_ERRCNT_EN
    localparam int ADJ_EXP = 2;
    localparam int SAT_EXP = 255;
`else
    localparam int ADJ_EXP = 0;
    localparam int SAT_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gray_decode_pipe_if #(.WIDTH(W)) bus ();

    gray_decode_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] bin;
        logic         err;
        int unsigned  edge_no;
    } ent_t;

    ent_t         pipe_q[$];
    logic [W-1:0] src[$];
    logic [W-1:0] dlv[$];

    int          checks = 0;
    int          failures = 0;
    int unsigned edge_cnt = 0;
    logic [W-1:0] m_prev;
    bit          m_prev_v;
    int          m_cnt;
    bit          rand_mode = 0;
    int          stall_lo = -1;
    int          stall_hi = -1;
    bit          saw_stall;

    function automatic logic [W-1:0] gray2bin(logic [W-1:0] gw);
        logic [W-1:0] r;
        r = gw;
        for (int s = 1; s < W; s++) r = r ^ (gw >> s);
        return r;
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef GRAY_DEC_ERRCNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model at negedge, update model at posedge
    task automatic step(output bit in_fire);
        bit           e_ir;
        bit           e_ov;
        bit           o_fire;
        ent_t         h;
        logic [W-1:0] gin;
        @(negedge clk);
        e_ir = !(pipe_q.size() == 2 && !bus.out_ready);
        e_ov = (pipe_q.size() > 0) && (pipe_q[0].edge_no < edge_cnt);
        chk("in_ready", bus.in_ready, e_ir);
        chk("out_valid", bus.out_valid, e_ov);
        if (e_ov) begin
            chk("b", bus.b, pipe_q[0].bin);
            chk("step_err", bus.step_err, pipe_q[0].err);
        end
        chk("err_cnt", bus.err_cnt, exp_cnt());
        if (!e_ir) saw_stall = 1;
        in_fire = bus.in_valid && e_ir && !rst;
        o_fire  = e_ov && bus.out_ready && !rst;
        gin     = bus.g;
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            pipe_q.delete();
            m_prev   = '0;
            m_prev_v = 0;
            m_cnt    = 0;
        end else begin
            if (o_fire) begin
                h = pipe_q.pop_front();
                dlv.push_back(h.bin);
                if (h.err && m_cnt < 255) m_cnt++;
            end
            if (in_fire) begin
                pipe_q.push_back('{bin: gray2bin(gin),
                                   err: (m_prev_v && ($countones(gin ^ m_prev) != 1)),
                                   edge_no: edge_cnt});
                m_prev   = gin;
                m_prev_v = 1;
            end
        end
        #1;
    endtask

    task automatic stream(input int budget);
        int cyc;
        bit f;
        cyc = 0;
        while ((src.size() > 0 || pipe_q.size() > 0) && cyc < budget) begin
            bus.in_valid  = (src.size() > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
            bus.g         = (src.size() > 0) ? src[0] : W'($urandom);
            bus.out_ready = rand_mode ? ($urandom_range(0, 3) != 0)
                                      : !(cyc >= stall_lo && cyc <= stall_hi);
            step(f);
            if (f) void'(src.pop_front());
            cyc++;
        end
        bus.in_valid = 0;
        chk("drain_timeout", src.size() + pipe_q.size(), 0);
    endtask

    task automatic do_reset();
        bit f;
        rst           = 1;
        bus.in_valid  = 1;
        bus.g         = 3'b101;
        bus.out_ready = 1;
        repeat (2) begin
            step(f);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_b", bus.b, 0);
            chk("rst_err_cnt", bus.err_cnt, 0);
        end
        rst          = 0;
        bus.in_valid = 0;
        #0;
        chk("rst_in_ready", bus.in_ready, 1);
        dlv.delete();
    endtask

    initial begin
        bit           f;
        logic [W-1:0] gw;

        rst           = 1;
        bus.in_valid  = 0;
        bus.g         = '0;
        bus.out_ready = 1;
        m_prev        = '0;
        m_prev_v      = 0;
        m_cnt         = 0;
        @(posedge clk);
        #1;

        // Reset with a word held on the input; it must never emerge
        do_reset();
        repeat (3) step(f);

        // Full Gray cycle then wrap to 000
        src = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        stream(100);
        chk("seq_count", dlv.size(), 9);
        for (int i = 0; i < dlv.size() && i < 9; i++) chk("seq_b", dlv[i], i % 8);

        // Adjacency violations: 000 -> 011 (two bits), 011 -> 011 (repeat)
        do_reset();
        src = '{3'b000, 3'b011, 3'b011};
        stream(50);
        chk("adj_err_cnt", bus.err_cnt, ADJ_EXP);

        // Backpressure window on cycles 3..6
        do_reset();
        saw_stall = 0;
        for (int i = 0; i < 8; i++) src.push_back(W'(i ^ (i >> 1)));
        stall_lo = 3;
        stall_hi = 6;
        stream(100);
        stall_lo = -1;
        stall_hi = -1;
        chk("bp_stalled", saw_stall, 1);
        chk("bp_count", dlv.size(), 8);
        for (int i = 0; i < dlv.size() && i < 8; i++) chk("bp_order", dlv[i], i);

        // 310 repeats of one word -> 309 errored deliveries
        do_reset();
        repeat (310) src.push_back(3'b000);
        stream(2000);
        chk("sat_err_cnt", bus.err_cnt, SAT_EXP);

        // Random traffic, mostly legal steps with occasional arbitrary jumps
        do_reset();
        gw = W'($urandom);
        repeat (300) begin
            if ($urandom_range(0, 4) != 0) gw = gw ^ W'(1 << $urandom_range(0, W - 1));
            else gw = W'($urandom);
            src.push_back(gw);
        end
        rand_mode = 1;
        stream(5000);
        rand_mode = 0;
        chk("rand_count", dlv.size(), 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
